camera_sequencer: RTL and testbench
===================================

// Module: camera_sequencer
// PURPOSE
//  Sequences the IR camera I2C link in place of the button pulse. After start, it issues the
//  6-entry camera init table as register writes, spaced by a gap timer. It then polls the
//  position register at a fixed rate and pulses frame_valid after each good read.
//  Sits between the slow-clock domain top level and the byte-level i2c master (cmd/done IF).
// PARAMETERS
//  PWRUP_WAIT  16'd1000  slow_clk cycles from start to first init write (camera power-up)
//  INIT_GAP    16'd100   idle cycles between successive init writes
//  POLL_DIV    16'd500   cycles from end of one poll to issue of next (must be >= 1)
//  MAX_RETRY   2'd3      NACK retries per init entry before FAULT
//  POLL_REG    8'h36     register read each poll
// PORTS
//  clk          in   1  slow_clk (I2C domain); all logic rising-edge
//  reset        in   1  async active-high reset
//  start        in   1  1-cycle pulse: (re)start init sequence
//  cmd_valid    out  1  command presented to i2c master
//  cmd_ready    in   1  master accepts command this cycle (when cmd_valid=1)
//  cmd_read     out  1  0=write cmd_reg<=cmd_wdata, 1=read burst from cmd_reg
//  cmd_reg      out  8  camera register address
//  cmd_wdata    out  8  write data (don't-care on reads, driven 0)
//  cmd_done     in   1  1-cycle pulse: accepted command finished on bus
//  cmd_nack     in   1  valid with cmd_done: slave NACKed
//  init_done    out  1  high once all 6 init writes ACKed; cleared by start/reset
//  frame_valid  out  1  1-cycle pulse: poll read completed with ACK
//  error        out  1  sticky: init entry exhausted retries; cleared by start/reset
//  state_dbg    out  4  current state encoding (for PIO0 debug header)
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; counters, table index and retry count 0.
//  Init table (index 0..5, {reg,data}):
//    {30,01} {30,08} {06,90} {08,C0} {1A,40} {33,33}
//  States:
//   IDLE   : wait for start -> PWRUP (timer=0).
//   PWRUP  : count to PWRUP_WAIT-1 -> ISSUE_I (idx=0, retry=0).
//   ISSUE_I: cmd_valid=1, read=0, reg/wdata=table[idx]; on cmd_ready -> WAIT_I.
//   WAIT_I : cmd_valid=0; on cmd_done:
//            ACK & idx<5 -> GAP, idx+1, retry=0.
//            ACK & idx=5 -> POLL_T, init_done=1.
//            NACK & retry<MAX_RETRY -> GAP, retry+1, same idx.
//            NACK & retry=MAX_RETRY -> FAULT, error=1.
//   GAP    : count INIT_GAP cycles -> ISSUE_I.
//   POLL_T : count POLL_DIV cycles -> ISSUE_P.
//   ISSUE_P: cmd_valid=1, read=1, reg=POLL_REG, wdata=0; on cmd_ready -> WAIT_P.
//   WAIT_P : on cmd_done:
//            ACK -> frame_valid pulse on the next edge.
//            NACK -> no pulse; error unaffected.
//            Either case -> POLL_T, timer=0.
//   FAULT  : outputs held (error=1, cmd_valid=0); only start or reset leaves.
//  Handshake: cmd_valid, cmd_read, cmd_reg and cmd_wdata are stable from assertion until the
//   cycle cmd_ready=1 (inclusive). At most one command is outstanding. cmd_done outside
//   WAIT_* is ignored.
//  start handling (highest priority over all other transitions):
//   - In IDLE, PWRUP, GAP, POLL_T, FAULT, or ISSUE_* before acceptance: go to PWRUP next edge.
//     Drop cmd_valid. Clear init_done/error, idx, retry and timer.
//   - In WAIT_*: set restart_pend and wait for cmd_done. Do not act on the result (no
//     frame_valid, no idx advance), then go to PWRUP. Further starts while pending are no-ops.
//   - start coincident with cmd_ready in ISSUE_*: the command counts as accepted; treat as WAIT_*.
//  Timers 16-bit, compare-equal then reset to 0; a parameter of 0 in PWRUP/GAP means 1 cycle.
//  Latency start->first cmd_valid = PWRUP_WAIT+1 cycles.
// TESTING
//  1. Reset, start, master ACKs all with ready=1 and done 3 cycles later -> 6 writes in
//     table order, init_done=1, first read reg=36 after POLL_DIV cycles.
//  2. NACK index 2 twice then ACK -> 3 attempts of {06,90}, each separated by INIT_GAP;
//     sequence completes with error=0.
//  3. NACK index 0 four times -> FAULT, error=1, cmd_valid=0. Then start -> error=0 and
//     re-init from {30,01}.
//  4. Polling with ACK/NACK/ACK -> exactly 2 frame_valid pulses, 1 cycle each; poll spacing
//     is POLL_DIV cycles.
//  5. start in WAIT_P with done arriving 5 cycles later -> no frame_valid; PWRUP entered the
//     cycle after done; next cmd is {30,01}.
//  6. Hold cmd_ready=0 for 10 cycles in ISSUE_I -> fields stable throughout. Assert reset
//     mid-sequence -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/camera_sequencer.sv
// camera_sequencer: drives the IR camera over the byte-level I2C master.
// After start it waits out camera power-up, writes the 6-entry init table
// (with NACK retries and a gap between writes), then polls the position
// register at a fixed rate and pulses frame_valid after every ACKed read.
module camera_sequencer #(
  parameter logic [15:0] PWRUP_WAIT = 16'd1000,
  parameter logic [15:0] INIT_GAP   = 16'd100,
  parameter logic [15:0] POLL_DIV   = 16'd500,
  parameter logic [1:0]  MAX_RETRY  = 2'd3,
  parameter logic [7:0]  POLL_REG   = 8'h36
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_read,
  output logic [7:0] cmd_reg,
  output logic [7:0] cmd_wdata,
  input  logic       cmd_done,
  input  logic       cmd_nack,
  output logic       init_done,
  output logic       frame_valid,
  output logic       error,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    PWRUP   = 4'd1,
    ISSUE_I = 4'd2,
    WAIT_I  = 4'd3,
    GAP     = 4'd4,
    POLL_T  = 4'd5,
    ISSUE_P = 4'd6,
    WAIT_P  = 4'd7,
    FAULT   = 4'd8
  } state_t;

  // Terminal timer values; a zero parameter still spends one cycle in the state.
  localparam logic [15:0] PWRUP_LAST = (PWRUP_WAIT == 16'd0) ? 16'd0 : PWRUP_WAIT - 16'd1;
  localparam logic [15:0] GAP_LAST   = (INIT_GAP   == 16'd0) ? 16'd0 : INIT_GAP   - 16'd1;
  localparam logic [15:0] POLL_LAST  = (POLL_DIV   == 16'd0) ? 16'd0 : POLL_DIV   - 16'd1;

  // Camera init table, {register, data}.
  function automatic logic [15:0] init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    init_entry = 16'h3001;
      3'd1:    init_entry = 16'h3008;
      3'd2:    init_entry = 16'h0690;
      3'd3:    init_entry = 16'h08C0;
      3'd4:    init_entry = 16'h1A40;
      3'd5:    init_entry = 16'h3333;
      default: init_entry = 16'h0000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic        init_done_q, init_done_d;
  logic        error_q, error_d;
  logic        pend_q, pend_d;
  logic        fv_d;
  logic        go_pwrup;
  logic        cmd_valid_q, cmd_read_q, frame_valid_q;
  logic [7:0]  cmd_reg_q, cmd_wdata_q;
  logic [15:0] entry_d;

  // Next-state logic; start (restart) overrides every other transition.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    init_done_d = init_done_q;
    error_d     = error_q;
    pend_d      = pend_q;
    fv_d        = 1'b0;
    go_pwrup    = 1'b0;
    case (state_q)
      IDLE: if (start) go_pwrup = 1'b1;
      PWRUP: begin
        if (start) go_pwrup = 1'b1;
        else if (timer_q == PWRUP_LAST) begin
          state_d = ISSUE_I;
          timer_d = 16'd0;
          idx_d   = 3'd0;
          retry_d = 2'd0;
        end else timer_d = timer_q + 16'd1;
      end
      ISSUE_I: begin
        // An accepted command must complete on the bus before any restart.
        if (cmd_ready) begin
          state_d = WAIT_I;
          pend_d  = start;
        end else if (start) go_pwrup = 1'b1;
      end
      WAIT_I: begin
        if (start) pend_d = 1'b1;
        if (cmd_done) begin
          if (pend_q || start) go_pwrup = 1'b1;
          else if (!cmd_nack) begin
            timer_d = 16'd0;
            retry_d = 2'd0;
            if (idx_q == 3'd5) begin
              state_d     = POLL_T;
              init_done_d = 1'b1;
            end else begin
              state_d = GAP;
              idx_d   = idx_q + 3'd1;
            end
          end else if (retry_q == MAX_RETRY) begin
            state_d = FAULT;
            error_d = 1'b1;
          end else begin
            state_d = GAP;
            timer_d = 16'd0;
            retry_d = retry_q + 2'd1;
          end
        end
      end
      GAP: begin
        if (start) go_pwrup = 1'b1;
        else if (timer_q == GAP_LAST) begin
          state_d = ISSUE_I;
          timer_d = 16'd0;
        end else timer_d = timer_q + 16'd1;
      end
      POLL_T: begin
        if (start) go_pwrup = 1'b1;
        else if (timer_q == POLL_LAST) begin
          state_d = ISSUE_P;
          timer_d = 16'd0;
        end else timer_d = timer_q + 16'd1;
      end
      ISSUE_P: begin
        if (cmd_ready) begin
          state_d = WAIT_P;
          pend_d  = start;
        end else if (start) go_pwrup = 1'b1;
      end
      WAIT_P: begin
        if (start) pend_d = 1'b1;
        if (cmd_done) begin
          if (pend_q || start) go_pwrup = 1'b1;
          else begin
            fv_d    = !cmd_nack;
            state_d = POLL_T;
            timer_d = 16'd0;
          end
        end
      end
      FAULT: if (start) go_pwrup = 1'b1;
      default: state_d = IDLE;
    endcase
    if (go_pwrup) begin
      state_d     = PWRUP;
      timer_d     = 16'd0;
      idx_d       = 3'd0;
      retry_d     = 2'd0;
      init_done_d = 1'b0;
      error_d     = 1'b0;
      pend_d      = 1'b0;
    end
  end

  assign entry_d = init_entry(idx_d);

  // State, counters and registered command/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= 16'd0;
      idx_q         <= 3'd0;
      retry_q       <= 2'd0;
      init_done_q   <= 1'b0;
      error_q       <= 1'b0;
      pend_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_read_q    <= 1'b0;
      cmd_reg_q     <= 8'd0;
      cmd_wdata_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      idx_q         <= idx_d;
      retry_q       <= retry_d;
      init_done_q   <= init_done_d;
      error_q       <= error_d;
      pend_q        <= pend_d;
      frame_valid_q <= fv_d;
      cmd_valid_q   <= (state_d == ISSUE_I) || (state_d == ISSUE_P);
      cmd_read_q    <= (state_d == ISSUE_P);
      cmd_reg_q     <= (state_d == ISSUE_I) ? entry_d[15:8] :
                       (state_d == ISSUE_P) ? POLL_REG : 8'd0;
      cmd_wdata_q   <= (state_d == ISSUE_I) ? entry_d[7:0] : 8'd0;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_read    = cmd_read_q;
  assign cmd_reg     = cmd_reg_q;
  assign cmd_wdata   = cmd_wdata_q;
  assign init_done   = init_done_q;
  assign frame_valid = frame_valid_q;
  assign error       = error_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_camera_sequencer.sv
// Directed bench for camera_sequencer with a small I2C-master model.
module tb_camera_sequencer;
  logic       clk = 1'b0;
  logic       reset, start, cmd_ready, cmd_done, cmd_nack;
  logic       cmd_valid, cmd_read, init_done, frame_valid, error;
  logic [7:0] cmd_reg, cmd_wdata;
  logic [3:0] state_dbg;

  localparam int PW = 8, GP = 4, PD = 6;

  camera_sequencer #(
    .PWRUP_WAIT(16'd8), .INIT_GAP(16'd4), .POLL_DIV(16'd6)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_done(cmd_done),
    .cmd_nack(cmd_nack), .init_done(init_done), .frame_valid(frame_valid),
    .error(error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int fv_cnt = 0;
  int checks = 0;
  int errors = 0;
  int t_ref = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

  typedef struct {
    logic       rd;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       nk;
    int         dly;   // expected cycles from t_ref to cmd_valid, -1 = skip
    logic       idn;   // expected init_done after completion
  } vec_t;

  vec_t t1[9];
  vec_t t2[8];
  vec_t t3[4];

  function automatic vec_t mk(logic rd, logic [7:0] rg, logic [7:0] wd,
                              logic nk, int dly, logic idn);
    vec_t v;
    v.rd = rd; v.rg = rg; v.wd = wd; v.nk = nk; v.dly = dly; v.idn = idn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for cmd_valid at a falling edge.
  task automatic wait_valid(input string nm, output bit ok);
    int w;
    w = 0;
    while (cmd_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    ok = (cmd_valid === 1'b1);
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Master model: accept one command, finish it 3 cycles later with ACK/NACK.
  task automatic serve(input vec_t v, input string nm);
    bit ok;
    wait_valid(nm, ok);
    if (!ok) return;
    if (v.dly >= 0) chk({nm, "_delay"}, cyc - t_ref, v.dly);
    chk({nm, "_cmd"}, {14'd0, cmd_read, cmd_reg, cmd_wdata}, {14'd0, v.rd, v.rg, v.wd});
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk({nm, "_valid_drop"}, cmd_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    cmd_done = 1'b1;
    cmd_nack = v.nk;
    @(negedge clk);
    cmd_done = 1'b0;
    cmd_nack = 1'b0;
    t_ref = cyc;
    if (v.rd) chk({nm, "_frame_valid"}, frame_valid, !v.nk);
    else      chk({nm, "_init_done"}, init_done, v.idn);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    t_ref = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    bit ok;
    int c, fvs;
    t1[0] = mk(0, 8'h30, 8'h01, 0, PW + 1, 0);
    t1[1] = mk(0, 8'h30, 8'h08, 0, GP, 0);
    t1[2] = mk(0, 8'h06, 8'h90, 0, GP, 0);
    t1[3] = mk(0, 8'h08, 8'hC0, 0, GP, 0);
    t1[4] = mk(0, 8'h1A, 8'h40, 0, GP, 0);
    t1[5] = mk(0, 8'h33, 8'h33, 0, GP, 1);
    t1[6] = mk(1, 8'h36, 8'h00, 0, PD, 1);
    t1[7] = mk(1, 8'h36, 8'h00, 1, PD, 1);
    t1[8] = mk(1, 8'h36, 8'h00, 0, PD, 1);
    t2[0] = mk(0, 8'h30, 8'h01, 0, PW + 1, 0);
    t2[1] = mk(0, 8'h30, 8'h08, 0, GP, 0);
    t2[2] = mk(0, 8'h06, 8'h90, 1, GP, 0);
    t2[3] = mk(0, 8'h06, 8'h90, 1, GP, 0);
    t2[4] = mk(0, 8'h06, 8'h90, 0, GP, 0);
    t2[5] = mk(0, 8'h08, 8'hC0, 0, GP, 0);
    t2[6] = mk(0, 8'h1A, 8'h40, 0, GP, 0);
    t2[7] = mk(0, 8'h33, 8'h33, 0, GP, 1);
    t3[0] = mk(0, 8'h30, 8'h01, 1, PW + 1, 0);
    t3[1] = mk(0, 8'h30, 8'h01, 1, GP, 0);
    t3[2] = mk(0, 8'h30, 8'h01, 1, GP, 0);
    t3[3] = mk(0, 8'h30, 8'h01, 1, GP, 0);

    reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0; cmd_nack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outputs", {cmd_valid, cmd_read, cmd_reg, cmd_wdata, init_done, frame_valid, error},
        32'd0);
    chk("rst_state", state_dbg, 4'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", state_dbg, 4'd0);

    // Full init with ACKs, then polls ACK/NACK/ACK.
    pulse_start();
    chk("pwrup_entered", state_dbg, 4'd1);
    foreach (t1[i]) serve(t1[i], $sformatf("t1_%0d", i));
    @(negedge clk);
    chk("t1_fv_count", fv_cnt, 2);
    chk("t1_error", error, 1'b0);

    // Restart from POLL_T; NACK index 2 twice then ACK.
    pulse_start();
    chk("t2_init_cleared", init_done, 1'b0);
    foreach (t2[i]) serve(t2[i], $sformatf("t2_%0d", i));
    chk("t2_error", error, 1'b0);

    // Four NACKs on index 0 end in FAULT.
    pulse_start();
    foreach (t3[i]) serve(t3[i], $sformatf("t3_%0d", i));
    chk("fault_error", error, 1'b1);
    chk("fault_state", state_dbg, 4'd8);
    chk("fault_valid", cmd_valid, 1'b0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("fault_sticky", {state_dbg, error, cmd_valid}, {4'd8, 1'b1, 1'b0});
    pulse_start();
    chk("fault_exit_error", error, 1'b0);
    chk("fault_exit_state", state_dbg, 4'd1);
    for (int i = 0; i < 6; i++) serve(t1[i], $sformatf("t4_%0d", i));

    // Restart while a poll is outstanding.
    wait_valid("t5_poll", ok);
    chk("t5_poll_delay", cyc - t_ref, PD);
    chk("t5_poll_cmd", {cmd_read, cmd_reg}, {1'b1, 8'h36});
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    start = 1'b1;
    c = cyc;
    fvs = fv_cnt;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t5_still_waitp", state_dbg, 4'd7);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("t5_done_cycle", cyc - c, 5);
    chk("t5_no_frame", frame_valid, 1'b0);
    chk("t5_pwrup", state_dbg, 4'd1);
    t_ref = cyc;
    serve(mk(0, 8'h30, 8'h01, 0, PW, 0), "t5_reinit");
    chk("t5_fv_count", fv_cnt, fvs);

    // Stall acceptance for 10 cycles; command fields must not move.
    wait_valid("t6_stall", ok);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t6_stable_%0d", i), {cmd_valid, cmd_read, cmd_reg, cmd_wdata},
          {1'b1, 1'b0, 8'h30, 8'h08});
      @(negedge clk);
    end
    serve(mk(0, 8'h30, 8'h08, 0, -1, 0), "t6_1");
    for (int i = 2; i < 6; i++) serve(t1[i], $sformatf("t6_%0d", i));
    wait_valid("t6_poll", ok);
    chk("t6_pre_reset", {cmd_valid, init_done}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("arst_outputs", {cmd_valid, cmd_read, cmd_reg, cmd_wdata, init_done, frame_valid, error},
        32'd0);
    chk("arst_state", state_dbg, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {state_dbg, cmd_valid}, {4'd0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
